// File: rtl/root_power_loader_pkg.sv
// rtl/root_power_loader_pkg.sv - shared sizing, state and row types for the twiddle-table loader
package root_power_loader_pkg;

  localparam int FSIZE   = 16;
  localparam int LOGE    = 2;
  localparam int LANES   = 2;
  localparam int ROWS    = 4;
  localparam int ADDR_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int STAGE_W = (LOGE > 1) ? $clog2(LOGE) : 1;
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;

  // W and WQ tables, each LOGE banks of ROWS rows of LANES words
  localparam int ROOT_LOAD_BEATS = 2 * LOGE * ROWS * LANES;

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_WQ, DONE} root_load_state_t;

  typedef logic [LANES-1:0][FSIZE-1:0] row_t;

endpackage

// File: rtl/root_power_loader_if.sv
// rtl/root_power_loader_if.sv - DMA word stream feeding the loader
interface root_power_loader_if;
  import root_power_loader_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [FSIZE-1:0] in_data;
  logic             in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/root_power_loader_packer.sv
// rtl/root_power_loader_packer.sv - rp_row_packer: lane counter, holding register, row-complete strobe
module rp_row_packer
  import root_power_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             beat,
  input  logic [FSIZE-1:0] data,
  output logic             row_complete,
  output row_t             row_data
);

  logic [LANE_W-1:0]             lane;
  logic [LANES-2:0][FSIZE-1:0]   hold;

  assign row_complete = beat && (lane == LANE_W'(LANES - 1));

  // The completing word bypasses the holding register so the row is whole on its beat
  always_comb begin
    row_data = '0;
    for (int i = 0; i < LANES - 1; i++) begin
      row_data[i] = hold[i];
    end
    row_data[LANES-1] = data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
      hold <= '0;
    end else if (clear) begin
      lane <= '0;
      hold <= '0;
    end else if (beat) begin
      lane <= row_complete ? '0 : lane + 1'b1;
      for (int i = 0; i < LANES - 1; i++) begin
        if (lane == LANE_W'(i)) hold[i] <= data;
      end
    end
  end

endmodule

// File: rtl/root_power_loader.sv
// rtl/root_power_loader.sv - packs DMA twiddle words into per-stage W/WQ bank row writes
module root_power_loader
  import root_power_loader_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  root_power_loader_if.slave                dma,
  output logic [LOGE-1:0][ADDR_W-1:0]       w_waddr,
  output logic [LOGE-1:0][LANES-1:0][FSIZE-1:0] w_wdata,
  output logic [LOGE-1:0][LANES-1:0]        w_wren,
  output logic [LOGE-1:0][ADDR_W-1:0]       wq_waddr,
  output logic [LOGE-1:0][LANES-1:0][FSIZE-1:0] wq_wdata,
  output logic [LOGE-1:0][LANES-1:0]        wq_wren,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  root_load_state_t  state;
  logic [ADDR_W-1:0] row;
  logic [STAGE_W-1:0] stage;
  logic              beat;
  logic              row_complete;
  logic              table_end;
  row_t              row_data;

  assign beat      = dma.in_valid && dma.in_ready;
  assign table_end = row_complete && (row == ADDR_W'(ROWS - 1)) && (stage == STAGE_W'(LOGE - 1));

  rp_row_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (!busy),
    .beat         (beat),
    .data         (dma.in_data),
    .row_complete (row_complete),
    .row_data     (row_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      row          <= '0;
      stage        <= '0;
      dma.in_ready <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      w_waddr      <= '0;
      w_wdata      <= '0;
      w_wren       <= '0;
      wq_waddr     <= '0;
      wq_wdata     <= '0;
      wq_wren      <= '0;
    end else begin
      w_waddr  <= '0;
      w_wdata  <= '0;
      w_wren   <= '0;
      wq_waddr <= '0;
      wq_wdata <= '0;
      wq_wren  <= '0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD_W;
            dma.in_ready <= 1'b1;
            busy         <= 1'b1;
            row          <= '0;
            stage        <= '0;
            err          <= 1'b0;
          end
        end
        LOAD_W, LOAD_WQ: begin
          if (beat) begin
            if (row_complete) begin
              if (state == LOAD_W) begin
                w_wren[stage]  <= '1;
                w_waddr[stage] <= row;
                w_wdata[stage] <= row_data;
              end else begin
                wq_wren[stage]  <= '1;
                wq_waddr[stage] <= row;
                wq_wdata[stage] <= row_data;
              end
              if (row == ADDR_W'(ROWS - 1)) begin
                row   <= '0;
                stage <= (stage == STAGE_W'(LOGE - 1)) ? '0 : stage + 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end
            // Only in_last exactly on the final WQ word is a clean finish
            if (dma.in_last || (state == LOAD_WQ && table_end)) begin
              state        <= DONE;
              dma.in_ready <= 1'b0;
              busy         <= 1'b0;
              err          <= !(state == LOAD_WQ && table_end && dma.in_last);
            end else if (table_end) begin
              state <= LOAD_WQ;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
